// File: rtl/trap_csr_ctrl.sv
// Exception/ertn commit sequencer and base exception CSR file for the WB stage.
// Optional timer CSRs (TCFG/TVAL/TICLR) are compiled in when TIMER_INT_EN is defined.
module trap_csr_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] EENTRY_RST   = 32'h1c008000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_ertn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_mask,
  input  logic [31:0] csr_wvalue,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic [7:0]  hw_int,
  output logic        int_pending,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        busy
);

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hc;
`ifdef TIMER_INT_EN
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
`endif

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        busy_q;

  logic [3:0]  crmd;       // {DA, IE, PLV}
  logic [2:0]  prmd;       // {PIE, PPLV}
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era;
  logic [25:0] eentry_va;
  logic [12:0] is_full;
`ifdef TIMER_INT_EN
  logic [31:0] tcfg;
  logic [31:0] tval;
`endif

  logic        idle;
  logic        exc_ev;
  logic        ertn_ev;
  logic        csr_wr;
  logic [31:0] wr_old;
  logic [31:0] wr_new;

  assign is_full = {1'b0, is_timer, 1'b0, is_hw, is_sw};

  function automatic logic [31:0] csr_read(input logic [13:0] num);
    logic [31:0] v;
    v = '0;
    case (num)
      CSR_CRMD:   v = {28'd0, crmd};
      CSR_PRMD:   v = {29'd0, prmd};
      CSR_ECFG:   v = {19'd0, ecfg_lie};
      CSR_ESTAT:  v = {1'b0, esubcode, ecode, 3'd0, is_full};
      CSR_ERA:    v = era;
      CSR_EENTRY: v = {eentry_va, 6'd0};
`ifdef TIMER_INT_EN
      CSR_TCFG:   v = tcfg;
      CSR_TVAL:   v = tval;
`endif
      default:    v = '0;
    endcase
    return v;
  endfunction

  // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    idle        = (state == IDLE);
    exc_ev      = idle & wb_valid & wb_exc;
    ertn_ev     = idle & wb_valid & wb_ertn & ~wb_exc;
    csr_wr      = idle & csr_we & ~exc_ev;
    wr_old      = csr_read(csr_num);
    wr_new      = (wr_old & ~csr_mask) | (csr_wvalue & csr_mask);
    csr_rvalue  = csr_read(csr_rnum);
    flush       = exc_ev | ertn_ev;
    flush_pc    = exc_ev ? {eentry_va, 6'd0} : era;
    int_pending = crmd[2] & (|(ecfg_lie & is_full));
  end

  assign busy = busy_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
            busy_q    <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Trap updates come after the write decode so they override it on the fields they touch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd      <= 4'h8;
      prmd      <= '0;
      ecfg_lie  <= '0;
      is_sw     <= '0;
      is_hw     <= '0;
      ecode     <= '0;
      esubcode  <= '0;
      era       <= '0;
      eentry_va <= EENTRY_RST[31:6];
    end else begin
      is_hw <= hw_int;
      if (csr_wr) begin
        case (csr_num)
          CSR_CRMD:   crmd      <= wr_new[3:0];
          CSR_PRMD:   prmd      <= wr_new[2:0];
          CSR_ECFG:   ecfg_lie  <= wr_new[12:0];
          CSR_ESTAT:  is_sw     <= wr_new[1:0];
          CSR_ERA:    era       <= wr_new;
          CSR_EENTRY: eentry_va <= wr_new[31:6];
          default: ;
        endcase
      end
      if (exc_ev) begin
        prmd      <= crmd[2:0];
        crmd[2:0] <= 3'b000;
        era       <= wb_pc;
        ecode     <= wb_ecode;
        esubcode  <= wb_esubcode;
      end else if (ertn_ev) begin
        crmd[2:0] <= prmd;
      end
    end
  end

`ifdef TIMER_INT_EN
  // Timer interrupt: a set from the 1->0 transition beats a same-cycle TICLR clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg     <= '0;
      tval     <= '0;
      is_timer <= 1'b0;
    end else begin
      if (csr_wr && csr_num == CSR_TICLR && wr_new[0]) begin
        is_timer <= 1'b0;
      end
      if (csr_wr && csr_num == CSR_TCFG) begin
        tcfg <= wr_new;
        tval <= {wr_new[31:2], 2'b00};
      end else if (tcfg[0] && tval != 32'd0) begin
        if (tval == 32'd1) begin
          is_timer <= 1'b1;
          tval     <= tcfg[1] ? {tcfg[31:2], 2'b00} : 32'd0;
        end else begin
          tval <= tval - 32'd1;
        end
      end
    end
  end
`else
  assign is_timer = 1'b0;
`endif

endmodule
